// File: rtl/hline_pkg.sv
// hline_pkg: state encoding and sizing constants shared by the hline AXI arbiter.
package hline_pkg;

  localparam int NREQ      = 2;
  localparam int MAX_BURST = 256;
  localparam int LEN_W     = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_BUSY    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way winner select. Round-robin on the last winner by default;
// HLINE_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
module rr_pick2 (
  input  logic [1:0] active,
  input  logic       last,
  output logic       win
);

`ifdef HLINE_ARB_FIXED_PRIO_EN
  assign win = ~active[0] & active[1];
`else
  // On a tie the requester that did not win last time goes next.
  assign win = (active == 2'b11) ? ~last : active[1];
`endif

endmodule

// File: rtl/hline_axi_arb.sv
// hline_axi_arb: shares one AXI burst master between two hline span engines.
// Build option: HLINE_ARB_FIXED_PRIO_EN selects fixed priority to engine 0.
//
// state       | meaning
// ARB_IDLE    | no grant; requests sampled, winner latched
// ARB_ISSUE   | grant held, m_go pulsed unless the burst is empty
// ARB_BUSY    | data beats routed to/from the winner until m_done
// ARB_RELEASE | req_done to the winner, pointer updated, grant dropped
module hline_axi_arb
  import hline_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [31:0]       req_addr0,
  input  logic [31:0]       req_addr1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  input  logic [31:0]       req_wdata0,
  input  logic [31:0]       req_wdata1,
  input  logic [3:0]        req_wbe0,
  input  logic [3:0]        req_wbe1,
  output logic [NREQ-1:0]   req_wpop,
  output logic [31:0]       req_rdata,
  output logic [NREQ-1:0]   req_rvalid,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   gnt,
  output logic              m_go,
  output logic              m_rnw,
  output logic [31:0]       m_addr,
  output logic [LEN_W-1:0]  m_len,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wbe,
  input  logic              m_wpop,
  input  logic [31:0]       m_rdata,
  input  logic              m_rvalid,
  input  logic              m_done
);

  arb_state_t       state;
  logic             last_win;
  logic [NREQ-1:0]  active;
  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic             busy;

  assign active   = req_rd | req_wr;
  assign pick_len = pick ? req_len1 : req_len0;

  rr_pick2 u_pick (
    .active (active),
    .last   (last_win),
    .win    (pick)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= ARB_IDLE;
      last_win <= 1'b1;
      gnt      <= '0;
      m_go     <= 1'b0;
      m_rnw    <= 1'b0;
      m_addr   <= '0;
      m_len    <= '0;
      req_done <= '0;
    end else begin
      m_go     <= 1'b0;
      req_done <= '0;
      case (state)
        ARB_IDLE: begin
          if (|active) begin
            gnt    <= {pick, ~pick};
            m_rnw  <= req_rd[pick];
            m_addr <= pick ? req_addr1 : req_addr0;
            m_len  <= pick_len;
            m_go   <= (pick_len != '0);
            state  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // An empty burst never touches the master and completes straight away.
          if (m_len != '0) begin
            state <= ARB_BUSY;
          end else begin
            req_done <= gnt;
            state    <= ARB_RELEASE;
          end
        end
        ARB_BUSY: begin
          if (m_done) begin
            req_done <= gnt;
            state    <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          last_win <= gnt[1];
          gnt      <= '0;
          state    <= ARB_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state == ARB_BUSY);
  assign req_wpop   = busy ? (gnt & {NREQ{m_wpop}})   : '0;
  assign req_rvalid = busy ? (gnt & {NREQ{m_rvalid}}) : '0;
  assign req_rdata  = m_rdata;
  assign m_wdata    = gnt[1] ? req_wdata1 : (gnt[0] ? req_wdata0 : '0);
  assign m_wbe      = gnt[1] ? req_wbe1   : (gnt[0] ? req_wbe0   : '0);

endmodule

// File: tb/tb_hline_axi_arb.sv
// tb_hline_axi_arb: engine and master models around the arbiter, with a
// timestamp-schedule reference checked every cycle plus directed scenarios.
`timescale 1ns/1ps
module tb_hline_axi_arb;

  localparam int INF = 1 << 30;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [1:0]  req_rd = '0, req_wr = '0;
  logic [31:0] req_addr0 = '0, req_addr1 = '0, req_wdata0 = '0, req_wdata1 = '0;
  logic [8:0]  req_len0 = '0, req_len1 = '0;
  logic [3:0]  req_wbe0 = '0, req_wbe1 = '0;
  logic        m_wpop = 1'b0, m_rvalid = 1'b0, m_done = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  req_wpop, req_rvalid, req_done, gnt;
  logic [31:0] req_rdata, m_addr, m_wdata;
  logic [8:0]  m_len;
  logic [3:0]  m_wbe;
  logic        m_go, m_rnw;

  hline_axi_arb dut (
    .clk(clk), .nreset(nreset), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_len0(req_len0), .req_len1(req_len1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_wbe0(req_wbe0), .req_wbe1(req_wbe1),
    .req_wpop(req_wpop), .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_done(req_done),
    .gnt(gnt), .m_go(m_go), .m_rnw(m_rnw), .m_addr(m_addr), .m_len(m_len),
    .m_wdata(m_wdata), .m_wbe(m_wbe), .m_wpop(m_wpop), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_done(m_done)
  );

  always #5 clk = ~clk;

  int cyc = 0, nvec = 0, nerr = 0;
  bit boot = 1'b1, chk_on = 1'b0, rnd_mode = 1'b0, rst_req = 1'b0, stray_req = 1'b0;
  int beat_pct = 70;

  // engine side
  bit          e_act[2], e_rd[2], e_wr[2], post[2], p_rd[2], p_wr[2], done_flag[2];
  logic [31:0] e_addr[2], p_addr[2];
  logic [8:0]  e_len[2], p_len[2];
  int          req_cyc[2];

  // master side
  bit ms_act = 1'b0, ms_rnw = 1'b0;
  int ms_rem = 0, beats = 0;

  // reference schedule
  int mdl_own = -1, mdl_last = 1, go_c = -1, bstart = INF, bend = INF, rel = INF;
  logic [31:0] s_addr = '0;
  logic [8:0]  s_len = '0;
  logic        s_rnw = 1'b0;

  // observation log
  int wpop_cnt[2], rv_cnt[2], done_cnt[2], reqdone_cyc[2];
  int go_cnt = 0, last_go = 0, mdone_cyc = 0;
  int glog[$];
  logic [1:0] prev_gnt = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, got, want);
    end
  endtask

  function automatic logic [8:0] rand_len();
    if ($urandom_range(0, 9) == 0) return 9'($urandom_range(0, 256));
    return 9'($urandom_range(0, 6));
  endfunction

  task automatic drive();
    bit rst;
    rst = rst_req || (rnd_mode && $urandom_range(0, 1999) == 0);
    rst_req = 1'b0;
    nreset = !(rst || boot);
    for (int i = 0; i < 2; i++) begin
      if (!nreset) begin
        e_act[i] = 1'b0; done_flag[i] = 1'b0;
      end else if (done_flag[i]) begin
        e_act[i] = 1'b0; done_flag[i] = 1'b0;
      end else if (!e_act[i] && post[i]) begin
        e_act[i] = 1'b1; post[i] = 1'b0; req_cyc[i] = cyc;
        e_rd[i] = p_rd[i]; e_wr[i] = p_wr[i]; e_addr[i] = p_addr[i]; e_len[i] = p_len[i];
      end else if (e_act[i] && rnd_mode && $urandom_range(0, 3) == 0) begin
        e_addr[i] = $urandom; e_len[i] = rand_len();
      end
      if (!e_act[i] && !post[i] && rnd_mode && $urandom_range(0, 5) == 0) begin
        p_rd[i] = 1'($urandom_range(0, 1));
        p_wr[i] = p_rd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
        p_addr[i] = $urandom; p_len[i] = rand_len(); post[i] = 1'b1;
      end
    end
    req_rd = {e_act[1] & e_rd[1], e_act[0] & e_rd[0]};
    req_wr = {e_act[1] & e_wr[1], e_act[0] & e_wr[0]};
    req_addr0 = e_addr[0]; req_addr1 = e_addr[1];
    req_len0 = e_len[0];   req_len1 = e_len[1];
    req_wdata0 = $urandom; req_wdata1 = $urandom;
    req_wbe0 = 4'($urandom); req_wbe1 = 4'($urandom);
    m_wpop = 1'b0; m_rvalid = 1'b0; m_done = 1'b0; m_rdata = $urandom;
    if (!nreset) begin
      ms_act = 1'b0;
    end else begin
      if (ms_act) begin
        if (ms_rem != 0) begin
          if ($urandom_range(0, 99) < beat_pct) begin
            if (ms_rnw) m_rvalid = 1'b1; else m_wpop = 1'b1;
            ms_rem--; beats++;
          end
        end else if ($urandom_range(0, 1) == 0) begin
          m_done = 1'b1; ms_act = 1'b0;
        end
      end else if (stray_req || (rnd_mode && $urandom_range(0, 15) == 0)) begin
        m_done = 1'b1; stray_req = 1'b0;
      end
      if (m_go) begin
        ms_act = 1'b1; ms_rem = int'(m_len); ms_rnw = m_rnw;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_act[i] = 0; post[i] = 0; done_flag[i] = 0; e_addr[i] = '0; e_len[i] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      drive();
    end
  end

  // reference compare and schedule update
  initial begin
    logic [1:0]  eg, ed, ew, er;
    logic [31:0] ewd;
    logic [3:0]  ewb;
    bit          inb, a0, a1;
    int          w;
    forever begin
      @(negedge clk);
      inb = (mdl_own >= 0) && (cyc >= bstart) && (cyc <= bend);
      eg  = (mdl_own == 0) ? 2'b01 : (mdl_own == 1) ? 2'b10 : 2'b00;
      ed  = (cyc == rel) ? eg : 2'b00;
      ew  = (inb && m_wpop) ? eg : 2'b00;
      er  = (inb && m_rvalid) ? eg : 2'b00;
      ewd = (mdl_own == 0) ? req_wdata0 : (mdl_own == 1) ? req_wdata1 : 32'h0;
      ewb = (mdl_own == 0) ? req_wbe0 : (mdl_own == 1) ? req_wbe1 : 4'h0;
      if (chk_on) begin
        chk("gnt", 64'(gnt), 64'(eg));
        chk("m_go", 64'(m_go), 64'(cyc == go_c));
        chk("req_done", 64'(req_done), 64'(ed));
        chk("req_wpop", 64'(req_wpop), 64'(ew));
        chk("req_rvalid", 64'(req_rvalid), 64'(er));
        chk("req_rdata", 64'(req_rdata), 64'(m_rdata));
        chk("m_wdata", 64'(m_wdata), 64'(ewd));
        chk("m_wbe", 64'(m_wbe), 64'(ewb));
        if (mdl_own >= 0) begin
          chk("m_addr", 64'(m_addr), 64'(s_addr));
          chk("m_len", 64'(m_len), 64'(s_len));
          chk("m_rnw", 64'(m_rnw), 64'(s_rnw));
        end
      end
      if (gnt != 2'b00 && prev_gnt == 2'b00) glog.push_back(int'(gnt[1]));
      prev_gnt = gnt;
      for (int i = 0; i < 2; i++) begin
        if (req_wpop[i]) wpop_cnt[i]++;
        if (req_rvalid[i]) rv_cnt[i]++;
        if (req_done[i]) begin done_cnt[i]++; reqdone_cyc[i] = cyc; done_flag[i] = 1'b1; end
      end
      if (m_go) begin go_cnt++; last_go = cyc; end
      if (m_done && inb) mdone_cyc = cyc;

      if (!nreset) begin
        mdl_own = -1; mdl_last = 1; go_c = -1; bstart = INF; bend = INF; rel = INF;
      end else if (mdl_own < 0) begin
        a0 = req_rd[0] | req_wr[0];
        a1 = req_rd[1] | req_wr[1];
        if (a0 || a1) begin
`ifdef HLINE_ARB_FIXED_PRIO_EN
          w = a0 ? 0 : 1;
`else
          w = (a0 && a1) ? 1 - mdl_last : (a0 ? 0 : 1);
`endif
          mdl_own = w;
          s_addr = (w == 1) ? req_addr1 : req_addr0;
          s_len  = (w == 1) ? req_len1 : req_len0;
          s_rnw  = req_rd[w];
          if (s_len != 0) begin
            go_c = cyc + 1; bstart = cyc + 2; bend = INF; rel = INF;
          end else begin
            go_c = -1; bstart = INF; bend = INF; rel = cyc + 2;
          end
        end
      end else begin
        if (m_done && inb) begin bend = cyc; rel = cyc + 1; end
        if (cyc == rel) begin mdl_last = mdl_own; mdl_own = -1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic post_req(input int i, input bit rd, input bit wr, input logic [31:0] a, input logic [8:0] l);
    p_rd[i] = rd; p_wr[i] = wr; p_addr[i] = a; p_len[i] = l; post[i] = 1'b1;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin wpop_cnt[i] = 0; rv_cnt[i] = 0; done_cnt[i] = 0; end
    go_cnt = 0; beats = 0; glog.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(!post[0] && !post[1] && !e_act[0] && !e_act[1] && mdl_own < 0) && n < 5000);
    if (n >= 5000) begin
      nvec++; nerr++;
      $display("FAIL %s: bus still busy after %0d cycles", nm, n);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_gnt"}, 64'(gnt), 64'(0));
    chk({nm, "_m_go"}, 64'(m_go), 64'(0));
    chk({nm, "_m_rnw"}, 64'(m_rnw), 64'(0));
    chk({nm, "_m_addr"}, 64'(m_addr), 64'(0));
    chk({nm, "_m_len"}, 64'(m_len), 64'(0));
    chk({nm, "_wpop"}, 64'(req_wpop), 64'(0));
    chk({nm, "_rvalid"}, 64'(req_rvalid), 64'(0));
    chk({nm, "_done"}, 64'(req_done), 64'(0));
    chk({nm, "_wdata"}, 64'(m_wdata), 64'(0));
    chk({nm, "_wbe"}, 64'(m_wbe), 64'(0));
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk_on = 1'b1;
    tick();
    check_zero("rst");
    boot = 1'b0;
    tick();

    // simultaneous reads; engine 0 re-requests once it has been served
    clr_stats();
    post_req(0, 1, 0, 32'h0000_2000, 9'd3);
    post_req(1, 1, 0, 32'h0000_3000, 9'd5);
    n = 0;
    while (!(done_cnt[0] >= 1 && !e_act[0]) && n < 3000) begin tick(); n++; end
    chk("tie_first_done", 64'(done_cnt[0] >= 1), 64'(1));
    post_req(0, 1, 0, 32'h0000_2100, 9'd2);
    wait_idle("tie");
    chk("tie_glog_n", 64'(glog.size()), 64'(3));
    if (glog.size() == 3) begin
      chk("tie_g0", 64'(glog[0]), 64'(0));
      chk("tie_g1", 64'(glog[1]), 64'(1));
      chk("tie_g2", 64'(glog[2]), 64'(0));
    end

    // long read by engine 1
    clr_stats();
    post_req(1, 1, 0, 32'h0000_8000, 9'd256);
    wait_idle("len256");
    chk("len256_rv1", 64'(rv_cnt[1]), 64'(256));
    chk("len256_rv0", 64'(rv_cnt[0]), 64'(0));
    chk("len256_go", 64'(go_cnt), 64'(1));

    // engine 0 write of four beats
    clr_stats();
    post_req(0, 0, 1, 32'h0000_1000, 9'd4);
    wait_idle("wr4");
    chk("wr4_go_lat", 64'(last_go - req_cyc[0]), 64'(1));
    chk("wr4_wpop0", 64'(wpop_cnt[0]), 64'(4));
    chk("wr4_wpop1", 64'(wpop_cnt[1]), 64'(0));
    chk("wr4_done_lat", 64'(reqdone_cyc[0] - mdone_cyc), 64'(1));
    chk("wr4_gnt_after", 64'(gnt), 64'(0));

    // tie right after engine 0 won
    clr_stats();
    post_req(0, 0, 1, 32'h0000_4000, 9'd1);
    post_req(1, 0, 1, 32'h0000_5000, 9'd1);
    wait_idle("rr");
    chk("rr_glog_n", 64'(glog.size()), 64'(2));
`ifdef HLINE_ARB_FIXED_PRIO_EN
    if (glog.size() != 0) chk("rr_first", 64'(glog[0]), 64'(0));
`else
    if (glog.size() != 0) chk("rr_first", 64'(glog[0]), 64'(1));
`endif

    // empty burst
    clr_stats();
    post_req(0, 1, 0, 32'h0000_6000, 9'd0);
    wait_idle("len0");
    chk("len0_done_lat", 64'(reqdone_cyc[0] - req_cyc[0]), 64'(2));
    chk("len0_go", 64'(go_cnt), 64'(0));
    chk("len0_done_n", 64'(done_cnt[0]), 64'(1));

    // reset half way through a 20-beat burst
    clr_stats();
    post_req(0, 1, 0, 32'h0000_7000, 9'd20);
    n = 0;
    while (beats < 10 && n < 3000) begin tick(); n++; end
    chk("rst_mid_beats", 64'(beats), 64'(10));
    rst_req = 1'b1;
    tick();
    tick();
    check_zero("rst_mid");
    repeat (3) tick();
    chk("rst_mid_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'(0));
    clr_stats();
    post_req(0, 0, 1, 32'h0000_7100, 9'd2);
    post_req(1, 0, 1, 32'h0000_7200, 9'd2);
    wait_idle("rst_fresh");
    if (glog.size() != 0) chk("rst_fresh_first", 64'(glog[0]), 64'(0));
    else chk("rst_fresh_glog_n", 64'(glog.size()), 64'(2));

    // m_done while idle must be ignored
    clr_stats();
    stray_req = 1'b1;
    repeat (4) tick();
    chk("stray_done", 64'(done_cnt[0] + done_cnt[1]), 64'(0));
    chk("stray_gnt", 64'(glog.size()), 64'(0));

    // randomized traffic
    rnd_mode = 1'b1;
    repeat (4000) tick();
    rnd_mode = 1'b0;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
